// File: rtl/digit_serial_adder.sv
// Multi-cycle adder: WIDTH-bit a + b + cin, DIGIT bits per clock, with the
// carry held in a register between digit steps and a valid/ready handshake.
module digit_serial_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STEPS  = WIDTH / DIGIT;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  generate
    if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_params
      $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q;
  logic [STEP_W-1:0] step_q;
  logic              carry_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [WIDTH-1:0]  sum_q;
  logic              cout_q;
  logic              ovf_q;

  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  acc_q;

  logic [DIGIT:0]    slice_d;
  logic [WIDTH-1:0]  acc_d;
  logic              msb_cin_d;
  logic              accept_d;

  assign accept_d = in_ready_q && in_valid;

  // Operands are shifted right each step, so the active digit is always the low slice.
  assign slice_d   = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
  assign msb_cin_d = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice_d[DIGIT-1];

  generate
    if (STEPS == 1) begin : g_single
      assign acc_d = slice_d[DIGIT-1:0];
    end else begin : g_multi
      assign acc_d = {slice_d[DIGIT-1:0], acc_q[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            carry_q    <= cin;
            step_q     <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          carry_q <= slice_d[DIGIT];
          step_q  <= step_q + 1'b1;
          if (step_q == LAST_STEP) begin
            sum_q       <= acc_d;
            cout_q      <= slice_d[DIGIT];
            ovf_q       <= msb_cin_d ^ slice_d[DIGIT];
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // A new operand is never taken on the completing edge; IDLE comes first.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept_d) begin
      a_q <= a;
      b_q <= b;
    end else if (state_q == RUN) begin
      a_q   <= a_q >> DIGIT;
      b_q   <= b_q >> DIGIT;
      acc_q <= acc_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: four configurations driven in lockstep, results
// compared against a plain-arithmetic reference with immediate assertions.
module tb_digit_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        cin_i = 1'b0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;

  logic        rdy [4];
  logic        vld [4];
  logic        co  [4];
  logic        ov  [4];
  logic [31:0] sm  [4];
  logic [7:0]  sum_w8;

  int checks = 0;
  int errors = 0;

  int steps_a [4] = '{4, 8, 1, 8};
  int wid_a   [4] = '{32, 32, 32, 8};

  logic [31:0] exp_sum [4];
  logic        exp_co  [4];
  logic        exp_ov  [4];

  always #5 clk = ~clk;

  digit_serial_adder #(.WIDTH(32), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
    .a(a_i), .b(b_i), .cin(cin_i), .out_valid(vld[0]), .out_ready(out_ready),
    .sum(sm[0]), .cout(co[0]), .ovf(ov[0]));

  digit_serial_adder #(.WIDTH(32), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
    .a(a_i), .b(b_i), .cin(cin_i), .out_valid(vld[1]), .out_ready(out_ready),
    .sum(sm[1]), .cout(co[1]), .ovf(ov[1]));

  digit_serial_adder #(.WIDTH(32), .DIGIT(32)) u_d32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
    .a(a_i), .b(b_i), .cin(cin_i), .out_valid(vld[2]), .out_ready(out_ready),
    .sum(sm[2]), .cout(co[2]), .ovf(ov[2]));

  digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[3]),
    .a(a_i[7:0]), .b(b_i[7:0]), .cin(cin_i), .out_valid(vld[3]), .out_ready(out_ready),
    .sum(sum_w8), .cout(co[3]), .ovf(ov[3]));

  assign sm[3] = {24'h0, sum_w8};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: whole-word addition on a w-bit view, overflow from operand/result signs.
  function automatic void ref_add(input logic [31:0] a, input logic [31:0] b, input logic c,
                                  input int w, output logic [31:0] s, output logic cy,
                                  output logic v);
    logic [32:0] full;
    logic [31:0] m;
    m    = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    full = {1'b0, a & m} + {1'b0, b & m} + {32'd0, c};
    s    = full[31:0] & m;
    cy   = full[w];
    v    = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic c);
    @(negedge clk);
    a_i = a; b_i = b; cin_i = c; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("in_ready_idle%0d", i), {31'd0, rdy[i]}, 32'd1);
      ref_add(a, b, c, wid_a[i], exp_sum[i], exp_co[i], exp_ov[i]);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_i = $urandom; b_i = $urandom; cin_i = 1'($urandom);
  endtask

  task automatic wait_result(input int hold, input bit ack);
    int lat [4];
    bit seen [4];
    for (int i = 0; i < 4; i++) begin lat[i] = 0; seen[i] = 1'b0; end
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (seen[0] && seen[1] && seen[2] && seen[3]) break;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (!seen[i] && vld[i]) begin seen[i] = 1'b1; lat[i] = cyc; end
      end
      in_valid = 1'($urandom); a_i = $urandom; b_i = $urandom; cin_i = 1'($urandom);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("done_seen%0d", i), {31'd0, seen[i]}, 32'd1);
      chk($sformatf("latency%0d", i), lat[i], steps_a[i]);
      chk($sformatf("sum%0d", i), sm[i], exp_sum[i]);
      chk($sformatf("cout%0d", i), {31'd0, co[i]}, {31'd0, exp_co[i]});
      chk($sformatf("ovf%0d", i), {31'd0, ov[i]}, {31'd0, exp_ov[i]});
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      in_valid = 1'($urandom); a_i = $urandom; b_i = $urandom;
      chk("hold_valid", {31'd0, vld[0]}, 32'd1);
      chk("hold_ready", {31'd0, rdy[0]}, 32'd0);
      chk("hold_sum", sm[0], exp_sum[0]);
      chk("hold_cout", {31'd0, co[0]}, {31'd0, exp_co[0]});
      chk("hold_ovf", {31'd0, ov[0]}, {31'd0, exp_ov[0]});
    end
    in_valid = 1'b0;
    if (ack) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("ack_valid%0d", i), {31'd0, vld[i]}, 32'd0);
        chk($sformatf("ack_ready%0d", i), {31'd0, rdy[i]}, 32'd1);
        chk($sformatf("ack_sum_held%0d", i), sm[i], exp_sum[i]);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
    end
  endtask

  initial begin
    // Power-up reset asserted mid-cycle
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_valid%0d", i), {31'd0, vld[i]}, 32'd0);
      chk($sformatf("rst_sum%0d", i), sm[i], 32'd0);
      chk($sformatf("rst_cout%0d", i), {31'd0, co[i]}, 32'd0);
      chk($sformatf("rst_ovf%0d", i), {31'd0, ov[i]}, 32'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) chk($sformatf("rel_ready%0d", i), {31'd0, rdy[i]}, 32'd1);

    // Carry across a digit boundary
    start_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
    wait_result(0, 1'b1);
    chk("t2_sum", sm[0], 32'h0000_0100);
    chk("t2_cout", {31'd0, co[0]}, 32'd0);
    chk("t2_ovf", {31'd0, ov[0]}, 32'd0);

    // Carry through every digit, signed overflow cases
    start_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    wait_result(0, 1'b1);
    chk("t3a_sum", sm[0], 32'h0000_0000);
    chk("t3a_cout", {31'd0, co[0]}, 32'd1);
    chk("t3a_ovf", {31'd0, ov[0]}, 32'd0);
    start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    wait_result(0, 1'b1);
    chk("t3b_sum", sm[0], 32'h8000_0000);
    chk("t3b_cout", {31'd0, co[0]}, 32'd0);
    chk("t3b_ovf", {31'd0, ov[0]}, 32'd1);
    start_op(32'h8000_0000, 32'h8000_0000, 1'b0);
    wait_result(0, 1'b1);
    chk("t3c_sum", sm[0], 32'h0000_0000);
    chk("t3c_cout", {31'd0, co[0]}, 32'd1);
    chk("t3c_ovf", {31'd0, ov[0]}, 32'd1);

    // Backpressure in DONE for five cycles
    start_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
    wait_result(5, 1'b1);

    // Reset asserted mid-cycle while holding a result
    start_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    wait_result(0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("midrst_valid%0d", i), {31'd0, vld[i]}, 32'd0);
      chk($sformatf("midrst_sum%0d", i), sm[i], 32'd0);
      chk($sformatf("midrst_cout%0d", i), {31'd0, co[i]}, 32'd0);
      chk($sformatf("midrst_ovf%0d", i), {31'd0, ov[i]}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) chk($sformatf("midrst_ready%0d", i), {31'd0, rdy[i]}, 32'd1);

    // Reset pulse during RUN step 2 discards the op
    start_op($urandom, $urandom, 1'($urandom));
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) chk($sformatf("abort_valid%0d", i), {31'd0, vld[i]}, 32'd0);
    end
    start_op(32'h1234_5678, 32'h1111_1111, 1'b0);
    wait_result(0, 1'b1);
    chk("t5_sum", sm[0], 32'h2345_6789);
    chk("t5_cout", {31'd0, co[0]}, 32'd0);

    // Random operands against the reference
    for (int n = 0; n < 24; n++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      if (n % 4 == 1) rb = ~ra;
      if (n % 4 == 2) begin ra[31] = 1'b0; rb[31] = 1'b0; end
      start_op(ra, rb, 1'($urandom));
      wait_result(n % 3, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
